// File: rtl/fifo_pop_ctrl.sv
// Read-side FIFO controller: issues pops, absorbs the 1-cycle read latency in a 2-entry skid buffer.
// Latency: pop sampled at edge E, word captured at E+1, out_valid high after E+1; one word/cycle sustained.
// Backpressure: a credit check on buffered + in-flight words stops pops; out_data/out_valid hold while stalled.
module fifo_pop_ctrl #(
    parameter int DATA_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data_out,
    output logic              fifo_pop,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              overflow_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        FULL = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [1:0]        occ;
    logic [1:0]        occ_next;
    logic              inflight;
    logic [DATA_W-1:0] buf_mem [2];
    logic              head;
    logic              tail;
    logic              hs;
    logic [2:0]        level;
    logic              drop;
    logic              capture;

    assign out_valid = (occ != 2'd0);
    assign out_data  = buf_mem[head];
    assign busy      = out_valid | inflight;
    assign hs        = out_valid & out_ready;

    // Words held after this edge if nothing new is popped; pops only while that stays below 2.
    assign level    = {1'b0, occ} + {2'b00, inflight} - {2'b00, hs};
    assign fifo_pop = enable & ~fifo_empty & ~reset & (level < 3'd2);

    // level==3 means a capture into a full buffer with no drain: the word is discarded.
    assign drop     = inflight & (level == 3'd3);
    assign capture  = inflight & ~drop;
    assign occ_next = drop ? 2'd2 : level[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ          <= 2'd0;
            inflight     <= 1'b0;
            head         <= 1'b0;
            tail         <= 1'b0;
            buf_mem[0]   <= '0;
            buf_mem[1]   <= '0;
            word_count   <= '0;
            overflow_err <= 1'b0;
        end else begin
            occ      <= occ_next;
            inflight <= fifo_pop;
            if (capture) begin
                buf_mem[tail] <= fifo_data_out;
                tail          <= ~tail;
            end
            if (hs) begin
                head       <= ~head;
                word_count <= word_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (drop) begin
                overflow_err <= 1'b1;
            end
        end
    end

    // Debug/coverage state tracker; it feeds no outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (fifo_pop) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                if (capture) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (occ_next == 2'd2) begin
                    state_next = FULL;
                end else if (occ_next == 2'd0) begin
                    state_next = fifo_pop ? FILL : IDLE;
                end
            end
            FULL: begin
                if (occ_next == 2'd1) begin
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// Bench for fifo_pop_ctrl: FIFO model, in-order scoreboard and word-count reference, plus directed corner cases.
module tb_fifo_pop_ctrl;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          out_ready = 1'b0;
    logic [DW-1:0] fifo_data_out = '0;

    logic          fifo_pop, out_valid, busy, overflow_err;
    logic [DW-1:0] out_data;
    logic [15:0]   word_count;

    logic          fifo_pop4, out_valid4, busy4, overflow_err4;
    logic [DW-1:0] out_data4;
    logic [3:0]    word_count4;

    fifo_pop_ctrl #(.DATA_W(DW), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data_out(fifo_data_out), .fifo_pop(fifo_pop), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .word_count(word_count),
        .busy(busy), .overflow_err(overflow_err)
    );

    fifo_pop_ctrl #(.DATA_W(DW), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data_out(fifo_data_out), .fifo_pop(fifo_pop4), .out_data(out_data4),
        .out_valid(out_valid4), .out_ready(out_ready), .word_count(word_count4),
        .busy(busy4), .overflow_err(overflow_err4)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    bit            pop_pending = 1'b0;
    bit            last_pop = 1'b0;
    int            n_pop = 0;
    int            n_hs = 0;
    int            pops_total = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic cyc(input bit en, input bit rdy);
        @(negedge clk);
        enable    = en;
        out_ready = rdy;
    endtask

    task automatic assert_reset();
        @(negedge clk);
        reset       = 1'b1;
        pop_pending = 1'b0;
        exp_q       = fifo_q;
    endtask

    // External FIFO: a pop sampled at an edge presents the head word shortly after that edge.
    always @(posedge clk) begin
        #1;
        if (pop_pending && !reset) begin
            if (fifo_q.size() > 0) fifo_data_out = fifo_q.pop_front();
            fifo_empty = (fifo_q.size() == 0);
        end
        pop_pending = 1'b0;
    end

    // Reference: words popped but not yet delivered, minus the one still in flight, are buffered.
    always @(negedge clk) begin : mon
        int buffered;
        bit ev, ehs, ebusy, epop;
        #2;
        if (reset) begin
            n_pop       = 0;
            n_hs        = 0;
            last_pop    = 1'b0;
            pop_pending = 1'b0;
        end else begin
            buffered = n_pop - int'(last_pop) - n_hs;
            ev       = (buffered > 0);
            ehs      = ev && out_ready;
            ebusy    = ev || last_pop;
            epop     = enable && (fifo_q.size() != 0) &&
                       (buffered + int'(last_pop) - int'(ehs) < 2);
            check("mon_valid", out_valid, ev);
            check("mon_pop", fifo_pop, epop);
            check("mon_busy", busy, ebusy);
            check("mon_ovf", overflow_err, 0);
            check("mon_wc", word_count, n_hs % 65536);
            check("mon_valid4", out_valid4, ev);
            check("mon_pop4", fifo_pop4, epop);
            check("mon_busy4", busy4, ebusy);
            check("mon_ovf4", overflow_err4, 0);
            check("mon_wc4", word_count4, n_hs % 16);
            if (ev && exp_q.size() > 0) begin
                check("mon_data", out_data, exp_q[0]);
                check("mon_data4", out_data4, exp_q[0]);
            end
            if (ehs) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                n_hs++;
            end
            if (fifo_pop) begin
                n_pop++;
                pops_total++;
            end
            last_pop    = fifo_pop;
            pop_pending = fifo_pop;
        end
    end

    typedef struct {
        bit            en;
        bit            rdy;
        bit            pop;
        bit            vld;
        logic [DW-1:0] dat;
        bit            busy;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int p0;
        tbl = '{
            '{1'b1, 1'b1, 1'b1, 1'b0, 10'h000, 1'b0},
            '{1'b1, 1'b1, 1'b1, 1'b0, 10'h000, 1'b1},
            '{1'b1, 1'b1, 1'b1, 1'b1, 10'h001, 1'b1},
            '{1'b1, 1'b1, 1'b1, 1'b1, 10'h002, 1'b1},
            '{1'b1, 1'b1, 1'b1, 1'b1, 10'h003, 1'b1},
            '{1'b1, 1'b1, 1'b1, 1'b1, 10'h004, 1'b1},
            '{1'b1, 1'b1, 1'b1, 1'b1, 10'h005, 1'b1},
            '{1'b1, 1'b1, 1'b1, 1'b1, 10'h006, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b1, 10'h007, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b1, 10'h008, 1'b1},
            '{1'b1, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0}
        };

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_wc", word_count, 0);
        check("rst_pop", fifo_pop, 0);
        check("rst_ovf", overflow_err, 0);
        @(negedge clk);
        reset = 1'b0;

        // Streaming 0x001..0x008 with out_ready held high
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            if (k == 0) begin
                for (int w = 1; w <= 8; w++) push(DW'(w));
            end
            enable    = tbl[k].en;
            out_ready = tbl[k].rdy;
            #1;
            check($sformatf("tbl%0d_pop", k), fifo_pop, tbl[k].pop);
            check($sformatf("tbl%0d_valid", k), out_valid, tbl[k].vld);
            check($sformatf("tbl%0d_busy", k), busy, tbl[k].busy);
            if (tbl[k].vld) check($sformatf("tbl%0d_data", k), out_data, tbl[k].dat);
        end
        check("stream_wc", word_count, 8);

        // Backpressure: stall 5 cycles mid-stream
        @(negedge clk);
        for (int w = 9; w <= 20; w++) push(DW'(w));
        enable = 1'b1;
        out_ready = 1'b1;
        repeat (3) cyc(1'b1, 1'b1);
        repeat (5) cyc(1'b1, 1'b0);
        #1;
        check("bp_pop", fifo_pop, 0);
        check("bp_valid", out_valid, 1);
        check("bp_occ", n_pop - int'(last_pop) - n_hs, 2);
        repeat (20) cyc(1'b1, 1'b1);
        #1;
        check("bp_drained", exp_q.size(), 0);
        check("bp_wc", word_count, 20);
        check("bp_ovf", overflow_err, 0);

        // enable dropped on the cycle after a pop
        @(negedge clk);
        for (int w = 21; w <= 23; w++) push(DW'(w));
        enable = 1'b1;
        out_ready = 1'b1;
        #1;
        check("en_first_pop", fifo_pop, 1);
        cyc(1'b0, 1'b1);
        #1;
        check("en_off_pop", fifo_pop, 0);
        check("en_off_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1);
            #1;
            check("en_hold_pop", fifo_pop, 0);
        end
        check("en_wc", word_count, 21);
        check("en_left", fifo_q.size(), 2);
        repeat (8) cyc(1'b1, 1'b1);
        #1;
        check("en_wc_done", word_count, 23);

        // Single word 0x3FF
        p0 = pops_total;
        @(negedge clk);
        push(10'h3FF);
        repeat (6) cyc(1'b1, 1'b1);
        #1;
        check("one_pops", pops_total - p0, 1);
        check("one_wc", word_count, 24);
        check("one_busy", busy, 0);
        check("one_state", 32'(dut.state), 0);

        // Reset mid-stream with the buffer full
        @(negedge clk);
        for (int w = 0; w < 10; w++) push(DW'(10'h100 + w));
        repeat (4) cyc(1'b1, 1'b0);
        #1;
        check("prerst_occ", n_pop - int'(last_pop) - n_hs, 2);
        assert_reset();
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_data", out_data, 0);
        check("arst_busy", busy, 0);
        check("arst_wc", word_count, 0);
        check("arst_wc4", word_count4, 0);
        check("arst_pop", fifo_pop, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_valid", out_valid, 0);
        repeat (15) cyc(1'b1, 1'b1);
        #1;
        check("post_rst_wc", word_count, 8);
        check("post_rst_drained", exp_q.size(), 0);

        // Counter wrap on the 4-bit instance
        assert_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int w = 0; w < 17; w++) push(DW'($urandom_range(0, 1023)));
        repeat (25) cyc(1'b1, 1'b1);
        #1;
        check("wrap_wc4", word_count4, 1);
        check("wrap_wc", word_count, 17);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (($urandom % 3) == 0 && fifo_q.size() < 8) push(DW'($urandom_range(0, 1023)));
            enable    = (($urandom % 8) != 0);
            out_ready = (($urandom % 4) != 0);
        end
        repeat (20) cyc(1'b1, 1'b1);
        #1;
        check("rand_drained", exp_q.size(), 0);
        check("rand_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
